muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit for the single-cycle MIPS core. It sits beside the register file.
- Consumes the two register read ports (rs/rt data) for MULT/MULTU/DIV/DIVU.
- Feeds HI/LO back to the register-file write-data mux for MFHI/MFLO.
- Raises a stall to freeze the PC while an operation is in flight.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  core clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  decoded MULT/MULTU/DIV/DIVU valid this cycle.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  in  XLEN  register read_data1 (multiplicand / dividend).
- rt_data  in  XLEN  register read_data2 (multiplier / divisor).
- mthi  in  1  write rs_data to HI.
- mtlo  in  1  write rs_data to LO.
- mfhi  in  1  instruction reads HI.
- mflo  in  1  instruction reads LO.
- hi  out  XLEN  architectural HI.
- lo  out  XLEN  architectural LO.
- busy  out  1  operation in flight.
- stall  out  1  freeze PC/regwrite this cycle.

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE, hi=0, lo=0, busy=0, stall=0, counter=0, internal accumulators=0.
- Reset mid-operation aborts immediately to IDLE with the same values; no partial result is committed.
- States: IDLE, RUN, FIX.
- IDLE -> RUN on a clk edge with start=1. That edge latches op, |rs|, |rt|, the sign bits and a zero-divisor flag; counter=0.
- RUN: one radix-2 step per edge; counter increments. RUN -> FIX on the edge where counter == XLEN-1, i.e. exactly XLEN RUN edges.
- FIX: one edge. Applies sign correction, writes hi/lo, returns to IDLE.
- Latency: result visible on hi/lo XLEN+2 edges after the start edge (34 for XLEN=32).
- busy = (state != IDLE), combinational from state.
- stall = busy & (start | mfhi | mflo | mthi | mtlo), combinational. Unrelated instructions proceed while the unit runs.
- Multiply: shift-add on magnitudes into a 2*XLEN product; {hi,lo} = product.
  - MULT negates the product in FIX if the operand signs differ.
  - MULTU applies no sign handling.
- Divide: restoring, one quotient bit per step. lo=quotient, hi=remainder.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - DIV 0x80000000 / -1: lo=0x80000000, hi=0 (natural wrap, no trap).
- Divide by zero (DIV or DIVU): still takes full latency. hi = rs_data as latched, lo = all ones.
- start while busy: ignored; stall held, and the core re-presents the instruction after busy falls.
- mthi/mtlo:
  - In IDLE they write on the clk edge; hi/lo update next cycle.
  - While busy they stall and are not applied.
  - mthi and mtlo in the same cycle both apply.
  - start plus mthi/mtlo in the same IDLE cycle: start wins, and mthi/mtlo are dropped (decoder guarantees exclusivity; assertion in the bench).
- mfhi/mflo in IDLE: no stall; hi/lo are valid combinationally for register writeback.
- On the FIX edge, an mfhi/mflo stall releases the next cycle and the reader sees the new value.
- All arithmetic is unsigned on magnitudes. Negation is two's complement modulo 2^XLEN or 2^(2*XLEN).

Decomposition:
- Shared package/include:
  - op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - state encodings (MD_IDLE, MD_RUN, MD_FIX)
  - XLEN default
- Natural sub-module: muldiv_datapath, holding the accumulator/shift registers and the add/subtract step. The FSM, counter, stall and HI/LO registers stay in muldiv_unit.

Test Plan:
- Reset low mid-RUN (edge 10 after MULT) -> hi=lo=0, busy=0 immediately, no later writeback.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 edges hi=0xFFFFFFFE, lo=0x00000001; busy high exactly edges 1..33.
- MULT -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
- DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- mflo asserted 1 edge after a DIVU 100/7 start -> stall held until FIX; first unstalled read returns lo=14 (hi=2).
- mthi 0x1234 in IDLE -> hi=0x1234 next cycle, no stall.
- mthi during RUN -> stall=1 and hi unchanged by it.
- start while busy -> ignored; the original result completes unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int MD_XLEN = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;

  // Divide ops have op[1] set; signed ops have op[0] clear.
  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 shift-add multiply / restoring divide datapath on operand magnitudes.
// Latency: one step per 'step' cycle; res_hi/res_lo are combinational from the registers.
// Backpressure: none; the controller decides when to load and step.
//
// Ports: clk, rst_n; load latches op/magnitudes/signs/zero-divisor flag from
// rs_data/rt_data; step advances one iteration; res_hi/res_lo give the
// sign-corrected result once XLEN steps have been taken.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  md_op_e          op_q, op_d;
  logic            sa_q, sa_d;        // dividend / multiplicand sign
  logic            sb_q, sb_d;        // divisor / multiplier sign
  logic            dz_q, dz_d;        // divide by zero
  logic [XLEN-1:0] mcand_q, mcand_d;  // multiplicand or divisor magnitude
  logic [XLEN-1:0] acc_hi_q, acc_hi_d;
  logic [XLEN-1:0] acc_lo_q, acc_lo_d;

  md_op_e          op_in;
  logic            rs_neg, rt_neg;
  logic [XLEN-1:0] rs_mag, rt_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;

  always_comb begin
    op_in  = md_op_e'(op);
    rs_neg = md_is_signed(op_in) & rs_data[XLEN-1];
    rt_neg = md_is_signed(op_in) & rt_data[XLEN-1];
    rs_mag = rs_neg ? -rs_data : rs_data;
    rt_mag = rt_neg ? -rt_data : rt_data;

    // Multiply: {acc_hi, acc_lo} is the product register, multiplier in the low half.
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out
    // the top and quotient bits in at the bottom.
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mcand_q});

    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;

    if (load) begin
      op_d     = op_in;
      sa_d     = rs_neg;
      sb_d     = rt_neg;
      dz_d     = md_is_div(op_in) & (rt_data == '0);
      acc_hi_d = '0;
      if (md_is_div(op_in)) begin
        acc_lo_d = rs_mag;
        mcand_d  = rt_mag;
      end else begin
        acc_lo_d = rt_mag;
        mcand_d  = rs_mag;
      end
    end else if (step) begin
      if (md_is_div(op_q)) begin
        acc_hi_d = div_ge ? XLEN'(div_shift - {1'b0, mcand_q}) : div_shift[XLEN-1:0];
        acc_lo_d = {acc_lo_q[XLEN-2:0], div_ge};
      end else begin
        acc_hi_d = mul_sum[XLEN:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= MD_MULT;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else begin
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   rem_fix, quo_fix;

  // Sign correction. With a zero divisor every trial subtract succeeds, so the
  // remainder register ends up holding the dividend magnitude; restoring the
  // dividend sign therefore yields rs_data as latched. Only the quotient needs
  // forcing to all ones.
  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = ((op_q == MD_MULT) && (sa_q ^ sb_q)) ? -prod : prod;
    rem_fix  = sa_q ? -acc_hi_q : acc_hi_q;
    if (dz_q) begin
      quo_fix = '1;
    end else if ((op_q == MD_DIV) && (sa_q ^ sb_q)) begin
      quo_fix = -acc_lo_q;
    end else begin
      quo_fix = acc_lo_q;
    end

    if (md_is_div(op_q)) begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end else begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit with MTHI/MTLO/MFHI/MFLO interlock.
// Latency: hi/lo updated XLEN+2 edges after the start edge (start, XLEN RUN, FIX).
// Backpressure: stall while busy for any start/mfhi/mflo/mthi/mtlo; those are dropped and re-presented.
//
// Ports: clk, rst_n (async active-low); start/op/rs_data/rt_data launch an op;
// mthi/mtlo write rs_data to HI/LO in IDLE; mfhi/mflo flag HI/LO reads;
// hi/lo architectural registers; busy = op in flight; stall = freeze PC.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = 6          // 2**CNT_W must exceed XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic            mfhi,
  input  logic            mflo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;

  logic             dp_load, dp_step;
  logic [XLEN-1:0]  res_hi, res_lo;

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dp_load),
    .step   (dp_step),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dp_load = 1'b0;
    dp_step = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        // start takes priority; the decoder never pairs it with mthi/mtlo.
        if (start) begin
          dp_load = 1'b1;
          cnt_d   = '0;
          state_d = MD_RUN;
        end else begin
          if (mthi) hi_d = rs_data;
          if (mtlo) lo_d = rs_data;
        end
      end
      MD_RUN: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != MD_IDLE);
  // Only instructions touching the unit freeze the PC; others keep flowing.
  assign stall = busy & (start | mfhi | mflo | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: reference model plus directed vectors.
// Latency: model commits a result XLEN+2 edges after the start edge.
// Backpressure: model ignores start/mthi/mtlo while an op is in flight.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_data, rt_data;
  logic            mthi, mtlo, mfhi, mflo;
  logic [XLEN-1:0] hi, lo;
  logic            busy, stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN (XLEN),
    .CNT_W(6)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .mfhi   (mfhi),
    .mflo   (mflo),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .stall  (stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Architectural result of one op: {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin
        p = sa * sb;
        return p;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model state: architectural HI/LO, edges left until the pending result lands.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi  = '0;
      m_lo  = '0;
      m_res = '0;
      m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) {m_hi, m_lo} = m_res;
    end else if (start) begin
      m_res = ref_md(op, rs_data, rt_data);
      m_rem = XLEN + 1;
    end else begin
      if (mthi) m_hi = rs_data;
      if (mtlo) m_lo = rs_data;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_hi", hi, m_hi);
    chk("cyc_lo", lo, m_lo);
    chk_bit("cyc_busy", busy, m_rem > 0);
    chk_bit("cyc_stall", stall, (m_rem > 0) && (start || mfhi || mflo || mthi || mtlo));
  end

  always @(posedge clk) begin
    if (rst_n && start && (mthi || mtlo)) $error("decoder exclusivity violated: start with mthi/mtlo");
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(output int nb);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      tick(1);
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", nb);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int nb);
    op      = o;
    rs_data = a;
    rt_data = b;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
    wait_idle(nb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; mfhi = 1'b0; mflo = 1'b0;
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_stall", stall, 1'b0);
    #11 rst_n = 1'b1;
    tick(1);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("multu_busy_cycles", n, 33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(2'b00, 32'hFFFF_FFF9, 32'd3, n);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(2'b11, 32'd100, 32'd0, n);
    chk("divu0_busy_cycles", n, 33);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd100);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);

    issue(2'b10, 32'hFFFF_FF9C, 32'd0, n);
    chk("div0_neg_lo", lo, 32'hFFFF_FFFF);
    chk("div0_neg_hi", hi, 32'hFFFF_FF9C);

    // mflo presented one edge after a start stalls until the result lands.
    op = 2'b11; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    tick(1);
    start = 1'b0;
    mflo  = 1'b1;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick(1);
    end
    chk("mflo_stall_cycles", n, 33);
    chk("mflo_lo", lo, 32'd14);
    chk("mflo_hi", hi, 32'd2);
    mflo = 1'b0;

    // mthi in IDLE: no stall, visible next cycle.
    rs_data = 32'h1234; mthi = 1'b1;
    #1;
    chk_bit("mthi_idle_stall", stall, 1'b0);
    tick(1);
    mthi = 1'b0;
    chk("mthi_idle_hi", hi, 32'h1234);
    chk("mthi_idle_lo", lo, 32'd14);

    // mthi and mtlo together both apply.
    rs_data = 32'h55; mthi = 1'b1; mtlo = 1'b1;
    tick(1);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", hi, 32'h55);
    chk("mthilo_lo", lo, 32'h55);

    // mthi while running is stalled and dropped.
    op = 2'b01; rs_data = 32'd3; rt_data = 32'd5; start = 1'b1;
    tick(1);
    start = 1'b0; rs_data = 32'hDEAD; mthi = 1'b1;
    #1;
    chk_bit("mthi_run_stall", stall, 1'b1);
    tick(3);
    mthi = 1'b0;
    wait_idle(n);
    chk("mthi_run_hi", hi, 32'h0);
    chk("mthi_run_lo", lo, 32'd15);

    // start while busy is ignored.
    op = 2'b00; rs_data = 32'd6; rt_data = 32'd7; start = 1'b1;
    tick(1);
    op = 2'b11; rs_data = 32'd9; rt_data = 32'd3;
    #1;
    chk_bit("start_busy_stall", stall, 1'b1);
    tick(3);
    start = 1'b0;
    wait_idle(n);
    chk("start_busy_hi", hi, 32'h0);
    chk("start_busy_lo", lo, 32'd42);
    tick(2);
    chk_bit("start_busy_no_rerun", busy, 1'b0);

    // Reset ten edges into a MULT aborts with no later writeback.
    op = 2'b00; rs_data = 32'd5; rt_data = 32'hFFFF_FFFE; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk_bit("abort_busy", busy, 1'b0);
    #4 rst_n = 1'b1;
    tick(40);
    chk("abort_late_hi", hi, 32'h0);
    chk("abort_late_lo", lo, 32'h0);
    chk_bit("abort_late_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
